// File: rtl/ctrl_pkg.sv
// Shared constants for the datapath controller: instruction opcode/op codes,
// FSM state encodings, writeback and ALU select encodings, instruction classes.
package ctrl_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int REGW_DEF  = 3;

    // Major opcodes (instr[15:13])
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;

    // Sub-op codes (instr[12:11])
    localparam logic [1:0] OPX_MOVR = 2'b00;
    localparam logic [1:0] OPX_MOVI = 2'b10;
    localparam logic [1:0] OPX_ADD  = 2'b00;
    localparam logic [1:0] OPX_CMP  = 2'b01;
    localparam logic [1:0] OPX_AND  = 2'b10;
    localparam logic [1:0] OPX_MVN  = 2'b11;

    // FSM states, kept as plain constants so the encoding is fixed
    typedef logic [2:0] state_t;
    localparam state_t S_WAIT    = 3'd0;
    localparam state_t S_DECODE  = 3'd1;
    localparam state_t S_GET_A   = 3'd2;
    localparam state_t S_GET_B   = 3'd3;
    localparam state_t S_COMPUTE = 3'd4;
    localparam state_t S_WR_REG  = 3'd5;
    localparam state_t S_WR_IMM  = 3'd6;

    // Writeback mux select
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // Instruction classes as seen by the sequencer
    typedef enum logic [2:0] {
        CLS_MOVI = 3'd0,
        CLS_MOVR = 3'd1,
        CLS_ALU2 = 3'd2,
        CLS_CMP  = 3'd3,
        CLS_MVN  = 3'd4,
        CLS_ILL  = 3'd5
    } iclass_e;

endpackage

// File: rtl/datapath_controller_instr_decoder.sv
// instr_decoder: purely combinational field extraction and classification of
// the latched instruction. Produces register fields, shift op, sign-extended
// immediates, instruction class and the ALU op to use in COMPUTE.
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int REGW  = REGW_DEF
) (
    input  logic [WIDTH-1:0] instr_i,
    output logic [REGW-1:0]  rn_o,
    output logic [REGW-1:0]  rd_o,
    output logic [REGW-1:0]  rm_o,
    output logic [1:0]       sh_o,
    output logic [WIDTH-1:0] sximm5_o,
    output logic [WIDTH-1:0] sximm8_o,
    output iclass_e          cls_o,
    output logic [1:0]       aluop_o
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode   = instr_i[15:13];
    assign op       = instr_i[12:11];
    assign rn_o     = instr_i[8 +: REGW];
    assign rd_o     = instr_i[5 +: REGW];
    assign rm_o     = instr_i[0 +: REGW];
    assign sh_o     = instr_i[4:3];
    assign sximm5_o = {{(WIDTH-5){instr_i[4]}}, instr_i[4:0]};
    assign sximm8_o = {{(WIDTH-8){instr_i[7]}}, instr_i[7:0]};

    // Classify opcode/op pair; anything not recognised is illegal
    always_comb begin
        cls_o   = CLS_ILL;
        aluop_o = ALU_ADD;
        if (opcode == OP_MOV && op == OPX_MOVI) begin
            cls_o = CLS_MOVI;
        end else if (opcode == OP_MOV && op == OPX_MOVR) begin
            cls_o = CLS_MOVR;
        end else if (opcode == OP_ALU) begin
            case (op)
                OPX_ADD: begin cls_o = CLS_ALU2; aluop_o = ALU_ADD;  end
                OPX_CMP: begin cls_o = CLS_CMP;  aluop_o = ALU_SUB;  end
                OPX_AND: begin cls_o = CLS_ALU2; aluop_o = ALU_AND;  end
                OPX_MVN: begin cls_o = CLS_MVN;  aluop_o = ALU_NOTB; end
                default: begin cls_o = CLS_ILL;  aluop_o = ALU_ADD;  end
            endcase
        end
    end

endmodule

// File: rtl/datapath_controller.sv
// datapath_controller: multi-cycle sequencer for one instruction at a time.
// Latches the instruction on start in WAIT, then walks DECODE and the
// operand/compute/writeback states, driving all datapath controls as Moore
// outputs of (state, latched instruction).
// Optional: define CTRL_PERF_CNT_EN to add a retired-instruction counter port.
module datapath_controller
    import ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int REGW  = REGW_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] instr,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [REGW-1:0]  readnum,
    output logic [REGW-1:0]  writenum,
    output logic [1:0]       vsel,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic             loadc,
    output logic             loads,
    output logic             write,
    output logic [WIDTH-1:0] sximm5,
    output logic [WIDTH-1:0] sximm8
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0]      retired
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;

    logic [REGW-1:0]  rn, rd, rm;
    logic [1:0]       sh;
    logic [1:0]       aluop;
    iclass_e          cls;

    instr_decoder #(.WIDTH(WIDTH), .REGW(REGW)) u_dec (
        .instr_i  (instr_q),
        .rn_o     (rn),
        .rd_o     (rd),
        .rm_o     (rm),
        .sh_o     (sh),
        .sximm5_o (sximm5),
        .sximm8_o (sximm8),
        .cls_o    (cls),
        .aluop_o  (aluop)
    );

    // Next-state and instruction latch; start only matters in WAIT
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            S_WAIT: begin
                if (start) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_MOVI:          state_d = S_WR_IMM;
                    CLS_MOVR, CLS_MVN: state_d = S_GET_B;
                    CLS_ALU2, CLS_CMP: state_d = S_GET_A;
                    default:           state_d = S_WAIT;
                endcase
            end
            S_GET_A:   state_d = S_GET_B;
            S_GET_B:   state_d = S_COMPUTE;
            S_COMPUTE: state_d = (cls == CLS_CMP) ? S_WAIT : S_WR_REG;
            S_WR_REG:  state_d = S_WAIT;
            S_WR_IMM:  state_d = S_WAIT;
            default:   state_d = S_WAIT;
        endcase
    end

    // State and latched instruction; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Moore control decode: every strobe defaults low, each state names its own
    always_comb begin
        busy     = (state_q != S_WAIT);
        done     = 1'b0;
        illegal  = 1'b0;
        readnum  = '0;
        writenum = '0;
        vsel     = VSEL_C;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = ALU_ADD;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        case (state_q)
            S_DECODE: begin
                if (cls == CLS_ILL) begin
                    illegal = 1'b1;
                    done    = 1'b1;
                end
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_COMPUTE: begin
                shift = sh;
                ALUop = aluop;
                // MOV reg passes B through as 0 + B
                asel  = (cls == CLS_MOVR);
                if (cls == CLS_CMP) begin
                    loads = 1'b1;
                    done  = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            S_WR_REG: begin
                vsel     = VSEL_C;
                writenum = rd;
                write    = 1'b1;
                done     = 1'b1;
            end
            S_WR_IMM: begin
                vsel     = VSEL_IMM8;
                writenum = rn;
                write    = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired_q, retired_d;

    assign retired_d = (done && !illegal) ? retired_q + 16'd1 : retired_q;
    assign retired   = retired_q;

    // Count legally completed instructions, wrapping at 16 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) retired_q <= '0;
        else          retired_q <= retired_d;
    end
`endif

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench for datapath_controller: a driver issues directed then
// random instructions and pushes each one's expected per-cycle control trace;
// a monitor compares every busy cycle against the queue and every idle cycle
// against the all-quiet pattern.
module tb_datapath_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        busy, done, illegal;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic        loada, loadb, asel, bsel, loadc, loads, write;
    logic [15:0] sximm5, sximm8;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] retired;
`endif

    always #5 clk = ~clk;

    datapath_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .instr    (instr),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired  (retired)
`endif
    );

    typedef struct packed {
        logic        busy, done, illegal;
        logic [2:0]  readnum, writenum;
        logic [1:0]  vsel;
        logic        loada, loadb, asel, bsel;
        logic [1:0]  shift, aluop;
        logic        loadc, loads, write;
        logic [15:0] sx5, sx8;
    } out_t;

    out_t        exp_q[$];
    logic [15:0] lat_instr = 16'h0;
    int          tests = 0;
    int          fails = 0;
    int          legal_cnt = 0;
    bit          mon_en = 1'b0;

    function automatic out_t sample();
        out_t r;
        r = '{busy, done, illegal, readnum, writenum, vsel, loada, loadb,
              asel, bsel, shift, ALUop, loadc, loads, write, sximm5, sximm8};
        return r;
    endfunction

    // Outside an instruction only the immediates (of the last latched word) show
    function automatic out_t idle_rec(input logic [15:0] ins);
        out_t r;
        r     = '0;
        r.sx5 = {{11{ins[4]}}, ins[4:0]};
        r.sx8 = {{8{ins[7]}}, ins[7:0]};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: the list of steps each instruction kind performs
    task automatic push_expected(input logic [15:0] ins);
        out_t base, r;
        bit movi, movr, add, cmp, andi, mvn;
        movi = (ins[15:11] == 5'b11010);
        movr = (ins[15:11] == 5'b11000);
        add  = (ins[15:11] == 5'b10100);
        cmp  = (ins[15:11] == 5'b10101);
        andi = (ins[15:11] == 5'b10110);
        mvn  = (ins[15:11] == 5'b10111);
        base = idle_rec(ins);
        base.busy = 1'b1;
        // decode step
        r = base;
        if (!(movi || movr || add || cmp || andi || mvn)) begin
            r.done = 1'b1; r.illegal = 1'b1;
            exp_q.push_back(r);
            return;
        end
        exp_q.push_back(r);
        legal_cnt++;
        if (movi) begin
            r = base; r.vsel = 2'b10; r.writenum = ins[10:8]; r.write = 1'b1; r.done = 1'b1;
            exp_q.push_back(r);
            return;
        end
        if (add || cmp || andi) begin
            r = base; r.readnum = ins[10:8]; r.loada = 1'b1;
            exp_q.push_back(r);
        end
        r = base; r.readnum = ins[2:0]; r.loadb = 1'b1;
        exp_q.push_back(r);
        r = base; r.shift = ins[4:3]; r.asel = movr;
        if (movr || add) r.aluop = 2'b00;
        else if (cmp)    r.aluop = 2'b01;
        else if (andi)   r.aluop = 2'b10;
        else             r.aluop = 2'b11;
        if (cmp) begin r.loads = 1'b1; r.done = 1'b1; end
        else     r.loadc = 1'b1;
        exp_q.push_back(r);
        if (!cmp) begin
            r = base; r.vsel = 2'b00; r.writenum = ins[7:5]; r.write = 1'b1; r.done = 1'b1;
            exp_q.push_back(r);
        end
    endtask

    function automatic logic [15:0] gen_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 6))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:11] = 5'b10100;
            3: r[15:11] = 5'b10101;
            4: r[15:11] = 5'b10110;
            5: r[15:11] = 5'b10111;
            default: begin
                while (r[15:11] inside {5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111})
                    r[15:11] = 5'($urandom);
            end
        endcase
        return r;
    endfunction

    // Monitor: one comparison per cycle, sampled after the active edge
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy", 64'(sample()), 64'(idle_rec(lat_instr)));
                end else begin
                    out_t e;
                    e = exp_q.pop_front();
                    chk("trace", 64'(sample()), 64'(e));
                end
            end else begin
                chk("idle", 64'(sample()), 64'(idle_rec(lat_instr)));
            end
        end
    end

    logic [15:0] dir_list [5] = '{16'hD007, 16'hD1FE, 16'hA148, 16'hA900, 16'h0000};
    localparam int NUM_INSTR = 300;

    initial begin
        int issued;
        logic [15:0] ins;
        issued = 0;
        #1;
        chk("reset_outputs", 64'(sample()), 64'(idle_rec(16'h0)));
`ifdef CTRL_PERF_CNT_EN
        chk("reset_retired", 64'(retired), 64'd0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int cyc = 0; cyc < 20000 && issued < NUM_INSTR; cyc++) begin
            @(negedge clk);
            if (!busy && (issued < 5 || $urandom_range(0, 3) != 0)) begin
                ins = (issued < 5) ? dir_list[issued] : gen_instr();
                start = 1'b1;
                instr = ins;
                push_expected(ins);
                lat_instr = ins;
                issued++;
            end else if (busy) begin
                // start while busy must be ignored
                start = 1'($urandom_range(0, 1));
                instr = 16'($urandom);
            end else begin
                start = 1'b0;
                instr = 16'($urandom);
            end
        end
        chk("issued_all", 64'(issued), 64'(NUM_INSTR));

        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
`ifdef CTRL_PERF_CNT_EN
        chk("retired_count", 64'(retired), 64'(legal_cnt & 16'hFFFF));
`endif

        // Abort ADD mid-instruction with an asynchronous reset in GET_B
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        instr = 16'hA148;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("get_b_before_reset", 64'({readnum, loadb}), 64'({3'd0, 1'b1}));
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(sample()), 64'(idle_rec(16'h0)));
        repeat (3) begin
            @(posedge clk);
            #1 chk("in_reset_quiet", 64'({busy, write, done}), 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 chk("after_reset_idle", 64'(sample()), 64'(idle_rec(16'h0)));
        end
`ifdef CTRL_PERF_CNT_EN
        chk("retired_after_reset", 64'(retired), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
